tone_sequencer: RTL and testbench
=================================

# tone_sequencer

Plays a programmed sequence of notes by configuring and gating the phase accumulator that feeds the PWM tone path. Holds a small writable note table: each entry is a 32-bit phase increment and a duration in sample ticks. On start, the block steps through the table, presents each increment to the accumulator, and pulses a phase clear at every note start. It inserts a silent gap between notes, and either stops or loops after the last step.

## Interface

Parameters:
- DEPTH, 16, number of note table entries; power of 2, at least 2. ADDR_W = $clog2(DEPTH).
- DUR_W, 16, width of the per-note duration field in ticks.
- GAP_TICKS, 2, silent ticks between consecutive notes. 0 means no gap.

Ports:
- i_clk  in  1  system clock; the only clock.
- i_rst  in  1  synchronous, active-high reset.
- i_tick  in  1  sample-rate strobe, one cycle wide; all durations count these.
- i_wr_en  in  1  note table write strobe.
- i_wr_addr  in  ADDR_W  table write address.
- i_wr_delta  in  32  phase increment to store; 0 marks a rest.
- i_wr_dur  in  DUR_W  duration to store; 0 marks an early terminator.
- i_start  in  1  start pulse.
- i_len  in  ADDR_W+1  number of steps to play, 1..DEPTH; sampled with i_start.
- i_loop  in  1  restart at step 0 after the last step; sampled live at end of sequence.
- i_stop  in  1  abort pulse.
- o_delta_phase  out  32  phase increment for the accumulator.
- o_phase_en  out  1  accumulator enable / tone audible.
- o_phase_clr  out  1  one-cycle accumulator clear at each note start.
- o_step  out  ADDR_W  index of the current step.
- o_busy  out  1  high from the cycle after start is accepted until return to IDLE.
- o_done  out  1  one-cycle pulse on natural completion.

## Operation

- Note table: DEPTH x (32+DUR_W) registers or distributed RAM. Not reset. Read is registered, with one cycle of latency.
- Writes are accepted only in IDLE; writes while busy are dropped.
- The state machine has five states: IDLE, LOAD, PLAY, GAP, DONE.
  - IDLE: if i_start=1 and i_len is in 1..DEPTH and i_stop=0, latch len, set step=0 and go to LOAD. Otherwise stay. i_len=0 or i_len>DEPTH means start is ignored.
  - LOAD: issue the table read for step and go to PLAY.
  - PLAY (entry cycle): if dur=0, go to DONE immediately, with o_phase_en=0 and no clr pulse. Otherwise:
    - load o_delta_phase with delta;
    - set o_phase_en = (delta != 0);
    - pulse o_phase_clr for exactly this cycle;
    - load the down-counter with dur.
  - PLAY (counting): decrement the counter on each i_tick. On the i_tick where counter==1, leave PLAY. If GAP_TICKS>0 go to GAP; else advance.
  - GAP: hold o_phase_en=0 and keep o_delta_phase. After GAP_TICKS i_ticks, advance.
  - Advance: if step+1 < len, increment step and go to LOAD. Else if i_loop=1, set step=0 and go to LOAD. Else go to DONE.
  - DONE: o_done=1 for one cycle, o_phase_en=0, then IDLE.
- i_stop in any non-IDLE state forces IDLE on the next edge. It sets o_phase_en=0 and clears o_busy. o_done is not pulsed, and o_delta_phase and o_step hold.
- i_start while busy is ignored.
- If i_start and i_wr_en arrive in the same IDLE cycle, both are accepted. LOAD reads the newly written data.
- i_tick in LOAD or the PLAY entry cycle is not counted. Duration counting begins the cycle after entry.

## Timing

- Reset values: o_delta_phase=0, o_phase_en=0, o_phase_clr=0, o_step=0, o_busy=0, o_done=0; state=IDLE.
- Start latency:
  - i_start is sampled at edge N.
  - o_busy=1 from N+1 (LOAD).
  - o_phase_clr, o_phase_en and o_delta_phase are valid from N+2 (PLAY entry).
- Note length: exactly dur i_ticks counted after the entry cycle, then GAP_TICKS ticks of silence.
- Step-to-step overhead: 2 cycles (LOAD plus PLAY entry), independent of i_tick.
- o_done asserts the cycle after leaving the last GAP (or PLAY). o_busy drops in the same cycle o_done deasserts.
- Reset mid-sequence behaves identically to reset from power-up.

## Test plan

- Reset then idle: all outputs 0. Pulse i_tick 10 times with no start: outputs stay 0.
- Program two entries, {delta=75591, dur=3} and {delta=151182, dur=2}. Set GAP_TICKS=2, start with len=2, loop=0:
  - o_phase_clr pulses twice;
  - o_phase_en is high for 3 then 2 ticks, with a 2-tick low gap;
  - o_done pulses once and o_busy falls.
- Rest and terminator: entry1 delta=0, dur=4 and entry2 dur=0, len=3:
  - entry1 gives o_phase_en=0 for 4 ticks, but o_phase_clr still pulses;
  - at entry2, DONE is reached, o_done pulses, and step 3 is never loaded.
- Loop: len=2 with i_loop=1 plays steps 0,1,0,1. Drop i_loop during step 1: finishes that pass, then o_done.
- i_stop mid-PLAY: o_phase_en=0 and o_busy=0 the next cycle, with no o_done. A subsequent i_start restarts at step 0.
- Ignored inputs:
  - i_wr_en while busy leaves the table unchanged, checked by readback via replay;
  - i_start while busy is ignored;
  - i_start with len=0 or len=DEPTH+1 keeps o_busy=0;
  - simultaneous i_start and i_stop in IDLE keeps o_busy=0.

Source files
------------

// File: rtl/tone_sequencer_if.sv
// Control, note-table write and accumulator-drive signals of the tone sequencer.
// The master side drives the i_* signals; the sequencer (slave) drives the o_* signals.
interface tone_sequencer_if #(
    parameter int DEPTH = 16,
    parameter int DUR_W = 16
);
    localparam int ADDR_W = $clog2(DEPTH);

    logic              i_tick;
    logic              i_wr_en;
    logic [ADDR_W-1:0] i_wr_addr;
    logic [31:0]       i_wr_delta;
    logic [DUR_W-1:0]  i_wr_dur;
    logic              i_start;
    logic [ADDR_W:0]   i_len;
    logic              i_loop;
    logic              i_stop;
    logic [31:0]       o_delta_phase;
    logic              o_phase_en;
    logic              o_phase_clr;
    logic [ADDR_W-1:0] o_step;
    logic              o_busy;
    logic              o_done;

    modport master (
        output i_tick, i_wr_en, i_wr_addr, i_wr_delta, i_wr_dur,
               i_start, i_len, i_loop, i_stop,
        input  o_delta_phase, o_phase_en, o_phase_clr, o_step, o_busy, o_done
    );

    modport slave (
        input  i_tick, i_wr_en, i_wr_addr, i_wr_delta, i_wr_dur,
               i_start, i_len, i_loop, i_stop,
        output o_delta_phase, o_phase_en, o_phase_clr, o_step, o_busy, o_done
    );
endinterface

// File: rtl/tone_sequencer.sv
// Note-table sequencer: steps through programmed {phase increment, duration} entries,
// driving and gating the phase accumulator of the PWM tone path.
module tone_sequencer #(
    parameter int DEPTH     = 16,
    parameter int DUR_W     = 16,
    parameter int GAP_TICKS = 2
) (
    input  logic             i_clk,
    input  logic             i_rst,
    tone_sequencer_if.slave  bus
);
    localparam int ADDR_W = $clog2(DEPTH);

    typedef enum logic [2:0] {IDLE, LOAD, PLAY, GAP, DONE} state_t;

    state_t            state_q, state_d;
    logic [31:0]       tbl_delta [DEPTH];
    logic [DUR_W-1:0]  tbl_dur   [DEPTH];
    logic [31:0]       rd_delta_q;
    logic [DUR_W-1:0]  rd_dur_q;
    logic [31:0]       delta_q, delta_d;
    logic [DUR_W-1:0]  cnt_q, cnt_d;
    logic [ADDR_W-1:0] step_q, step_d;
    logic [ADDR_W:0]   len_q, len_d;
    logic [ADDR_W:0]   step_nxt;
    logic              entry_q;
    logic              start_ok, last_step, cnt_one, advance, note_on;

    assign step_nxt  = {1'b0, step_q} + (ADDR_W+1)'(1);
    assign last_step = step_nxt >= len_q;
    assign cnt_one   = cnt_q == DUR_W'(1);
    assign start_ok  = bus.i_start && !bus.i_stop && (bus.i_len != '0)
                       && (bus.i_len <= (ADDR_W+1)'(DEPTH));

    // NOTE: every variable gets a default before the case so no path leaves it unassigned (no latches).
    always_comb begin
        state_d = state_q;
        step_d  = step_q;
        cnt_d   = cnt_q;
        len_d   = len_q;
        delta_d = delta_q;
        advance = 1'b0;
        case (state_q)
            IDLE: if (start_ok) begin
                state_d = LOAD;
                step_d  = '0;
                len_d   = bus.i_len;
            end
            LOAD: state_d = PLAY;
            PLAY: if (entry_q) begin
                if (rd_dur_q == '0) begin
                    state_d = DONE;
                end else begin
                    delta_d = rd_delta_q;
                    cnt_d   = rd_dur_q;
                end
            end else if (bus.i_tick) begin
                if (!cnt_one) begin
                    cnt_d = cnt_q - DUR_W'(1);
                end else if (GAP_TICKS > 0) begin
                    state_d = GAP;
                    cnt_d   = DUR_W'(GAP_TICKS);
                end else begin
                    advance = 1'b1;
                end
            end
            GAP: if (bus.i_tick) begin
                if (cnt_one) advance = 1'b1;
                else         cnt_d   = cnt_q - DUR_W'(1);
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase

        if (advance) begin
            if (!last_step) begin
                state_d = LOAD;
                step_d  = step_nxt[ADDR_W-1:0];
            end else if (bus.i_loop) begin
                state_d = LOAD;
                step_d  = '0;
            end else begin
                state_d = DONE;
            end
        end

        // Abort leaves the last presented increment and step index visible.
        if (bus.i_stop && state_q != IDLE) begin
            state_d = IDLE;
            step_d  = step_q;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    always_ff @(posedge i_clk) begin
        if (i_rst) state_q <= IDLE;
        else       state_q <= state_d;
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            step_q  <= '0;
            cnt_q   <= '0;
            len_q   <= '0;
            delta_q <= '0;
            entry_q <= 1'b0;
        end else begin
            step_q  <= step_d;
            cnt_q   <= cnt_d;
            len_q   <= len_d;
            delta_q <= delta_d;
            entry_q <= (state_q == LOAD) && (state_d == PLAY);
        end
    end

    // NOTE: the note table and its read register are deliberately not reset; nothing reads them before a LOAD.
    always_ff @(posedge i_clk) begin
        if (bus.i_wr_en && state_q == IDLE) begin
            tbl_delta[bus.i_wr_addr] <= bus.i_wr_delta;
            tbl_dur[bus.i_wr_addr]   <= bus.i_wr_dur;
        end
        if (state_q == LOAD) begin
            rd_delta_q <= tbl_delta[step_q];
            rd_dur_q   <= tbl_dur[step_q];
        end
    end

    // On the entry cycle the fresh table word drives the outputs directly; delta_q holds it afterwards.
    assign note_on           = (state_q == PLAY) && entry_q && (rd_dur_q != '0);
    assign bus.o_delta_phase = note_on ? rd_delta_q : delta_q;
    assign bus.o_phase_clr   = note_on;
    assign bus.o_phase_en    = (state_q == PLAY)
                               && (entry_q ? (note_on && rd_delta_q != '0) : (delta_q != '0));
    assign bus.o_step        = step_q;
    assign bus.o_busy        = state_q != IDLE;
    assign bus.o_done        = state_q == DONE;
endmodule

// File: tb/tb_tone_sequencer.sv
// Directed bench for tone_sequencer: plays short programs under a fixed tick pattern and
// compares per-note clear pulses, audible/silent tick counts and handshake timing.
module tb_tone_sequencer;
    localparam int DEPTH     = 16;
    localparam int DUR_W     = 16;
    localparam int GAP_TICKS = 2;

    logic clk = 1'b0;
    logic rst;
    int   n_vec = 0;
    int   n_err = 0;

    logic [31:0] clr_delta [$];
    int          clr_step  [$];
    int          en_t      [$];
    int          low_t     [$];
    int          done_n;
    int          done_step;
    int          fin;

    tone_sequencer_if #(.DEPTH(DEPTH), .DUR_W(DUR_W)) bus ();

    tone_sequencer #(.DEPTH(DEPTH), .DUR_W(DUR_W), .GAP_TICKS(GAP_TICKS)) dut (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic write_entry(input int addr, input logic [31:0] delta, input logic [DUR_W-1:0] dur);
        @(negedge clk);
        bus.i_wr_en    = 1'b1;
        bus.i_wr_addr  = addr[3:0];
        bus.i_wr_delta = delta;
        bus.i_wr_dur   = dur;
        @(negedge clk);
        bus.i_wr_en    = 1'b0;
    endtask

    // Returns at the negedge of the cycle after the start edge (LOAD if accepted).
    task automatic start_seq(input logic [4:0] len, input logic loop);
        @(negedge clk);
        bus.i_start = 1'b1;
        bus.i_len   = len;
        bus.i_loop  = loop;
        @(negedge clk);
        bus.i_start = 1'b0;
    endtask

    // Ticks every `period` cycles; per note records delta/step at the clear pulse, ticks while
    // audible (entry excluded) and ticks while silent-but-busy, until o_done.
    task automatic play(input int period, input int drop_loop_at, input bit poke);
        clr_delta.delete();
        clr_step.delete();
        en_t.delete();
        low_t.delete();
        done_n    = 0;
        done_step = -1;
        fin       = 0;
        for (int c = 0; c < 3000 && fin == 0; c++) begin
            @(negedge clk);
            bus.i_wr_en = 1'b0;
            bus.i_start = 1'b0;
            bus.i_tick  = (c % period) == 0;
            if (bus.o_phase_clr) begin
                clr_delta.push_back(bus.o_delta_phase);
                clr_step.push_back(int'(bus.o_step));
                en_t.push_back(0);
                low_t.push_back(0);
                if (clr_delta.size() == drop_loop_at) bus.i_loop = 1'b0;
                if (poke && clr_delta.size() == 1) begin
                    bus.i_wr_en    = 1'b1;
                    bus.i_wr_addr  = '0;
                    bus.i_wr_delta = 32'd999;
                    bus.i_wr_dur   = 16'd7;
                    bus.i_start    = 1'b1;
                    bus.i_len      = 5'd1;
                end
            end else if (bus.i_tick && en_t.size() > 0) begin
                if (bus.o_phase_en)
                    en_t[en_t.size()-1] = en_t[en_t.size()-1] + 1;
                else if (bus.o_busy && !bus.o_done)
                    low_t[low_t.size()-1] = low_t[low_t.size()-1] + 1;
            end
            if (bus.o_done) begin
                done_n++;
                done_step = int'(bus.o_step);
                fin       = 1;
            end
        end
        bus.i_tick  = 1'b0;
        bus.i_wr_en = 1'b0;
        bus.i_start = 1'b0;
        check("play_reached_done", fin, 1);
        @(negedge clk);
        check("busy_after_done", bus.o_busy, 1'b0);
        check("done_one_cycle", bus.o_done, 1'b0);
    endtask

    initial begin
        int any_out;
        bus.i_tick = 0; bus.i_wr_en = 0; bus.i_wr_addr = '0; bus.i_wr_delta = '0;
        bus.i_wr_dur = '0; bus.i_start = 0; bus.i_len = '0; bus.i_loop = 0; bus.i_stop = 0;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;

        check("rst_delta", bus.o_delta_phase, 0);
        check("rst_en",    bus.o_phase_en, 0);
        check("rst_clr",   bus.o_phase_clr, 0);
        check("rst_step",  bus.o_step, 0);
        check("rst_busy",  bus.o_busy, 0);
        check("rst_done",  bus.o_done, 0);

        any_out = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            bus.i_tick = 1'b1;
            @(negedge clk);
            bus.i_tick = 1'b0;
            if (bus.o_phase_en || bus.o_phase_clr || bus.o_busy || bus.o_done) any_out = 1;
        end
        check("idle_ticks_quiet", any_out, 0);

        // Two notes, ticks every 3 cycles.
        write_entry(0, 32'd75591, 16'd3);
        write_entry(1, 32'd151182, 16'd2);
        start_seq(5'd2, 1'b0);
        play(3, 0, 1'b0);
        check("two_n_clr",  clr_delta.size(), 2);
        check("two_delta0", clr_delta[0], 75591);
        check("two_delta1", clr_delta[1], 151182);
        check("two_step1",  clr_step[1], 1);
        check("two_en0",    en_t[0], 3);
        check("two_en1",    en_t[1], 2);
        check("two_gap0",   low_t[0], 2);
        check("two_gap1",   low_t[1], 2);
        check("two_done_n", done_n, 1);

        // Tick every cycle: ticks in LOAD are silent, ticks on the entry cycle are not counted.
        start_seq(5'd2, 1'b0);
        play(1, 0, 1'b0);
        check("dense_en0",  en_t[0], 3);
        check("dense_en1",  en_t[1], 2);
        check("dense_low0", low_t[0], 3);
        check("dense_low1", low_t[1], 2);

        // Write and start attempted while busy must be dropped.
        start_seq(5'd2, 1'b0);
        play(3, 0, 1'b1);
        check("poke_n_clr", clr_delta.size(), 2);
        start_seq(5'd2, 1'b0);
        play(3, 0, 1'b0);
        check("replay_delta0", clr_delta[0], 75591);
        check("replay_en0",    en_t[0], 3);
        check("replay_delta1", clr_delta[1], 151182);

        // Rest then early terminator.
        write_entry(1, 32'd0, 16'd4);
        write_entry(2, 32'd12345, 16'd0);
        start_seq(5'd3, 1'b0);
        play(3, 0, 1'b0);
        check("rest_n_clr",  clr_delta.size(), 2);
        check("rest_delta1", clr_delta[1], 0);
        check("rest_en1",    en_t[1], 0);
        check("rest_low1",   low_t[1], 6);
        check("term_step",   done_step, 2);
        check("term_done_n", done_n, 1);

        // Loop, dropping i_loop during the second pass of step 1.
        write_entry(1, 32'd151182, 16'd2);
        start_seq(5'd2, 1'b1);
        play(3, 4, 1'b0);
        bus.i_loop = 1'b0;
        check("loop_n_clr", clr_delta.size(), 4);
        check("loop_step0", clr_step[0], 0);
        check("loop_step1", clr_step[1], 1);
        check("loop_step2", clr_step[2], 0);
        check("loop_step3", clr_step[3], 1);
        check("loop_done_n", done_n, 1);

        // Write and start in the same IDLE cycle: LOAD sees the new word.
        @(negedge clk);
        bus.i_wr_en = 1'b1; bus.i_wr_addr = '0; bus.i_wr_delta = 32'd200000; bus.i_wr_dur = 16'd1;
        bus.i_start = 1'b1; bus.i_len = 5'd1; bus.i_loop = 1'b0;
        @(negedge clk);
        bus.i_wr_en = 1'b0; bus.i_start = 1'b0;
        play(3, 0, 1'b0);
        check("same_n_clr", clr_delta.size(), 1);
        check("same_delta", clr_delta[0], 200000);
        check("same_en",    en_t[0], 1);
        write_entry(0, 32'd75591, 16'd3);

        // Start latency, then abort mid-PLAY.
        start_seq(5'd2, 1'b0);
        check("lat_load_busy", bus.o_busy, 1);
        check("lat_load_clr",  bus.o_phase_clr, 0);
        check("lat_load_en",   bus.o_phase_en, 0);
        @(negedge clk);
        check("lat_entry_clr",   bus.o_phase_clr, 1);
        check("lat_entry_en",    bus.o_phase_en, 1);
        check("lat_entry_delta", bus.o_delta_phase, 75591);
        check("lat_entry_step",  bus.o_step, 0);
        @(negedge clk);
        check("lat_clr_single", bus.o_phase_clr, 0);
        check("lat_play_en",    bus.o_phase_en, 1);
        bus.i_stop = 1'b1;
        @(negedge clk);
        bus.i_stop = 1'b0;
        check("stop_en",    bus.o_phase_en, 0);
        check("stop_busy",  bus.o_busy, 0);
        check("stop_done",  bus.o_done, 0);
        check("stop_delta", bus.o_delta_phase, 75591);
        check("stop_step",  bus.o_step, 0);
        @(negedge clk);
        check("stop_no_done", bus.o_done, 0);
        start_seq(5'd2, 1'b0);
        play(3, 0, 1'b0);
        check("restart_n_clr", clr_delta.size(), 2);
        check("restart_step0", clr_step[0], 0);

        // Illegal lengths and start with stop are ignored.
        start_seq(5'd0, 1'b0);
        check("len0_busy", bus.o_busy, 0);
        start_seq(5'd17, 1'b0);
        check("len17_busy", bus.o_busy, 0);
        @(negedge clk);
        bus.i_start = 1'b1; bus.i_len = 5'd2; bus.i_stop = 1'b1;
        @(negedge clk);
        bus.i_start = 1'b0; bus.i_stop = 1'b0;
        check("start_stop_busy", bus.o_busy, 0);
        @(negedge clk);
        check("start_stop_busy2", bus.o_busy, 0);

        // Reset mid-sequence.
        start_seq(5'd2, 1'b0);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("mid_rst_delta", bus.o_delta_phase, 0);
        check("mid_rst_en",    bus.o_phase_en, 0);
        check("mid_rst_clr",   bus.o_phase_clr, 0);
        check("mid_rst_step",  bus.o_step, 0);
        check("mid_rst_busy",  bus.o_busy, 0);
        check("mid_rst_done",  bus.o_done, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
